// File: rtl/ex_operand_stage.sv
// ID/EX operand stage: captures decoded instructions, resolves operands through forwarding and
// stalls on load-use hazards. Define EX_FWD_WB_EN to forward from WB; otherwise a WB match stalls.
module ex_operand_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [4:0]      id_rs1_addr,
  input  logic [4:0]      id_rs2_addr,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_use_imm,
  input  logic [2:0]      id_alu_op,
  input  logic [4:0]      id_rd_addr,
  input  logic            id_rd_we,
  input  logic            id_is_load,
  input  logic [XLEN-1:0] fwd_ex_data,
  input  logic [4:0]      fwd_mem_rd,
  input  logic            fwd_mem_we,
  input  logic [XLEN-1:0] fwd_mem_data,
  input  logic [4:0]      fwd_wb_rd,
  input  logic            fwd_wb_we,
  input  logic [XLEN-1:0] fwd_wb_data,
  input  logic            flush,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] operand_a,
  output logic [XLEN-1:0] operand_b,
  output logic [2:0]      alu_op,
  output logic [4:0]      ex_rd_addr,
  output logic            ex_rd_we,
  output logic            ex_is_load
);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_op_a;
  logic [XLEN-1:0] r_op_b;
  logic [2:0]      r_alu_op;
  logic [4:0]      r_rd;
  logic            r_rd_we;
  logic            r_is_load;

  logic            w_adv;
  logic            w_cap;
  logic            w_hazard;
  logic            w_ld_hz;
  logic            w_wb_hz;
  logic            w_ex_fwd_ok;
  logic            w_a_ex, w_a_mem, w_a_wb;
  logic            w_b_ex, w_b_mem, w_b_wb;
  logic [XLEN-1:0] w_op_a;
  logic [XLEN-1:0] w_rs2_val;
  logic [XLEN-1:0] w_op_b;

  assign w_adv = (r_state == S_EMPTY) | ex_ready;
  assign w_cap = w_adv & id_valid & !w_hazard & !flush;

  // Source match flags per forwarding path; a held load never forwards from EX.
  assign w_ex_fwd_ok = (r_state == S_FULL) & r_rd_we & !r_is_load;
  assign w_a_ex  = w_ex_fwd_ok & (r_rd == id_rs1_addr);
  assign w_a_mem = fwd_mem_we & (fwd_mem_rd == id_rs1_addr);
  assign w_a_wb  = fwd_wb_we & (fwd_wb_rd == id_rs1_addr);
  assign w_b_ex  = w_ex_fwd_ok & (r_rd == id_rs2_addr);
  assign w_b_mem = fwd_mem_we & (fwd_mem_rd == id_rs2_addr);
  assign w_b_wb  = fwd_wb_we & (fwd_wb_rd == id_rs2_addr);

  assign w_ld_hz = (r_state == S_FULL) & r_is_load & r_rd_we & (r_rd != 5'd0) &
                   ((r_rd == id_rs1_addr) | (!id_use_imm & (r_rd == id_rs2_addr)));

`ifdef EX_FWD_WB_EN
  assign w_wb_hz = 1'b0;
`else
  // A source that only WB could supply waits one cycle for the register file write.
  logic w_unused_wb;
  assign w_unused_wb = ^fwd_wb_data;
  assign w_wb_hz = ((id_rs1_addr != 5'd0) & w_a_wb & !w_a_ex & !w_a_mem) |
                   (!id_use_imm & (id_rs2_addr != 5'd0) & w_b_wb & !w_b_ex & !w_b_mem);
`endif

  assign w_hazard = w_ld_hz | w_wb_hz;

  always_comb begin
    w_op_a = id_rs1_data;
    if (id_rs1_addr == 5'd0)  w_op_a = '0;
    else if (w_a_ex)          w_op_a = fwd_ex_data;
    else if (w_a_mem)         w_op_a = fwd_mem_data;
`ifdef EX_FWD_WB_EN
    else if (w_a_wb)          w_op_a = fwd_wb_data;
`endif
  end

  always_comb begin
    w_rs2_val = id_rs2_data;
    if (id_rs2_addr == 5'd0)  w_rs2_val = '0;
    else if (w_b_ex)          w_rs2_val = fwd_ex_data;
    else if (w_b_mem)         w_rs2_val = fwd_mem_data;
`ifdef EX_FWD_WB_EN
    else if (w_b_wb)          w_rs2_val = fwd_wb_data;
`endif
  end

  assign w_op_b = id_use_imm ? id_imm : w_rs2_val;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_EMPTY;
    else     r_state <= w_state_nxt;
  end

  // Next state: flush empties regardless of downstream, otherwise capture or bubble when advancing
  always_comb begin
    w_state_nxt = r_state;
    if (flush)      w_state_nxt = S_EMPTY;
    else if (w_cap) w_state_nxt = S_FULL;
    else if (w_adv) w_state_nxt = S_EMPTY;
  end

  // Output decode
  always_comb begin
    ex_valid = (r_state == S_FULL);
    id_ready = w_adv & !w_hazard & !flush;
  end

  // Payload registers update only on capture so a stall or bubble leaves them untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_alu_op  <= 3'd0;
      r_rd      <= 5'd0;
      r_rd_we   <= 1'b0;
      r_is_load <= 1'b0;
    end else if (w_cap) begin
      r_op_a    <= w_op_a;
      r_op_b    <= w_op_b;
      r_alu_op  <= id_alu_op;
      r_rd      <= id_rd_addr;
      r_rd_we   <= id_rd_we;
      r_is_load <= id_is_load;
    end
  end

  assign operand_a  = r_op_a;
  assign operand_b  = r_op_b;
  assign alu_op     = r_alu_op;
  assign ex_rd_addr = r_rd;
  assign ex_rd_we   = r_rd_we;
  assign ex_is_load = r_is_load;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: expected captures are queued when driven and
// compared when the stage presents them to execute.
module tb_ex_operand_stage;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic        id_ready;
  logic [4:0]  id_rs1_addr, id_rs2_addr;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic        id_use_imm;
  logic [2:0]  id_alu_op;
  logic [4:0]  id_rd_addr;
  logic        id_rd_we, id_is_load;
  logic [31:0] fwd_ex_data;
  logic [4:0]  fwd_mem_rd;
  logic        fwd_mem_we;
  logic [31:0] fwd_mem_data;
  logic [4:0]  fwd_wb_rd;
  logic        fwd_wb_we;
  logic [31:0] fwd_wb_data;
  logic        flush;
  logic        ex_valid, ex_ready;
  logic [31:0] operand_a, operand_b;
  logic [2:0]  alu_op;
  logic [4:0]  ex_rd_addr;
  logic        ex_rd_we, ex_is_load;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic        we;
    logic        ld;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   n_assert = 0;
  int   n_fail   = 0;

  ex_operand_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_use_imm(id_use_imm), .id_alu_op(id_alu_op),
    .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
    .fwd_ex_data(fwd_ex_data), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_we(fwd_mem_we),
    .fwd_mem_data(fwd_mem_data), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_we(fwd_wb_we),
    .fwd_wb_data(fwd_wb_data), .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .operand_a(operand_a), .operand_b(operand_b), .alu_op(alu_op),
    .ex_rd_addr(ex_rd_addr), .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e_val);
    n_assert++;
    assert (obs === e_val) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, e_val);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [31:0] d1,
                       input logic [4:0] rs2, input logic [31:0] d2, input logic ui,
                       input logic [31:0] imm, input logic [2:0] op, input logic [4:0] rd,
                       input logic we, input logic ld);
    id_valid = v;  id_rs1_addr = rs1; id_rs1_data = d1; id_rs2_addr = rs2; id_rs2_data = d2;
    id_use_imm = ui; id_imm = imm; id_alu_op = op; id_rd_addr = rd; id_rd_we = we;
    id_is_load = ld;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                      input logic [4:0] rd, input logic we, input logic ld);
    exp_t e;
    e.a = a; e.b = b; e.op = op; e.rd = rd; e.we = we; e.ld = ld;
    sb.push_back(e);
  endtask

  // Advance one edge; any queued capture must now be presented to execute.
  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      last = e;
      chk({tag, ".valid"}, 32'(ex_valid), 32'd1);
      chk({tag, ".a"}, operand_a, e.a);
      chk({tag, ".b"}, operand_b, e.b);
      chk({tag, ".op"}, 32'(alu_op), 32'(e.op));
      chk({tag, ".rd"}, 32'(ex_rd_addr), 32'(e.rd));
      chk({tag, ".we"}, 32'(ex_rd_we), 32'(e.we));
      chk({tag, ".ld"}, 32'(ex_is_load), 32'(e.ld));
    end
  endtask

  task automatic chk_hold(input string tag);
    chk({tag, ".valid"}, 32'(ex_valid), 32'd1);
    chk({tag, ".a"}, operand_a, last.a);
    chk({tag, ".b"}, operand_b, last.b);
    chk({tag, ".op"}, 32'(alu_op), 32'(last.op));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"}, 32'(ex_valid), 32'd0);
    chk({tag, ".a"}, operand_a, 32'd0);
    chk({tag, ".b"}, operand_b, 32'd0);
    chk({tag, ".op"}, 32'(alu_op), 32'd0);
    chk({tag, ".rd"}, 32'(ex_rd_addr), 32'd0);
    chk({tag, ".we"}, 32'(ex_rd_we), 32'd0);
    chk({tag, ".ld"}, 32'(ex_is_load), 32'd0);
  endtask

  task automatic clr_fwd();
    fwd_mem_rd = 5'd0; fwd_mem_we = 1'b0; fwd_mem_data = 32'd0;
    fwd_wb_rd  = 5'd0; fwd_wb_we  = 1'b0; fwd_wb_data  = 32'd0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ex_ready = 1'b1; fwd_ex_data = 32'd0;
    clr_fwd();
    drive(1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 32'd0, 3'd0, 5'd0, 1'b0, 1'b0);
    tick("rst0");
    tick("rst1");
    chk_zero("reset");
    rst = 1'b0;
    #1;
    chk("reset.id_ready", 32'(id_ready), 32'd1);

    // Back-to-back dependency through EX forwarding
    drive(1'b1, 5'd2, 32'h5, 5'd3, 32'h7, 1'b0, 32'd0, 3'd0, 5'd1, 1'b1, 1'b0);
    push(32'h5, 32'h7, 3'd0, 5'd1, 1'b1, 1'b0);
    tick("add_x1");
    fwd_ex_data = 32'h10;
    drive(1'b1, 5'd1, 32'h99, 5'd4, 32'h3, 1'b0, 32'd0, 3'd1, 5'd6, 1'b1, 1'b0);
    #1;
    chk("dep.id_ready", 32'(id_ready), 32'd1);
    push(32'h10, 32'h3, 3'd1, 5'd6, 1'b1, 1'b0);
    tick("dep");

    // Load-use: one bubble, then resolve from MEM
    drive(1'b1, 5'd2, 32'h100, 5'd0, 32'd0, 1'b1, 32'h4, 3'd0, 5'd5, 1'b1, 1'b1);
    push(32'h100, 32'h4, 3'd0, 5'd5, 1'b1, 1'b1);
    tick("lw_x5");
    drive(1'b1, 5'd5, 32'h0, 5'd0, 32'h0, 1'b0, 32'd0, 3'd2, 5'd7, 1'b1, 1'b0);
    #1;
    chk("lu.id_ready_stall", 32'(id_ready), 32'd0);
    tick("lu_bubble");
    chk("lu.bubble_valid", 32'(ex_valid), 32'd0);
    fwd_mem_rd = 5'd5; fwd_mem_we = 1'b1; fwd_mem_data = 32'hDEADBEEF;
    #1;
    chk("lu.id_ready_after", 32'(id_ready), 32'd1);
    push(32'hDEADBEEF, 32'h0, 3'd2, 5'd7, 1'b1, 1'b0);
    tick("lu_mem");

    // Forwarding priority: MEM beats WB; x0 always reads zero
    fwd_mem_rd = 5'd3; fwd_mem_we = 1'b1; fwd_mem_data = 32'h1;
    fwd_wb_rd  = 5'd3; fwd_wb_we  = 1'b1; fwd_wb_data  = 32'h2;
    drive(1'b1, 5'd3, 32'h33, 5'd0, 32'h44, 1'b0, 32'd0, 3'd4, 5'd0, 1'b1, 1'b0);
    push(32'h1, 32'h0, 3'd4, 5'd0, 1'b1, 1'b0);
    tick("prio");
    fwd_ex_data = 32'h88;
    fwd_mem_rd = 5'd0; fwd_mem_data = 32'h55;
    fwd_wb_rd  = 5'd0; fwd_wb_data  = 32'h66;
    drive(1'b1, 5'd0, 32'h77, 5'd0, 32'h78, 1'b0, 32'd0, 3'd5, 5'd8, 1'b1, 1'b0);
    #1;
    chk("x0.id_ready", 32'(id_ready), 32'd1);
    push(32'h0, 32'h0, 3'd5, 5'd8, 1'b1, 1'b0);
    tick("x0");
    clr_fwd();

    // Immediate path ignores an rs2 that matches a held load
    drive(1'b1, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 32'h8, 3'd0, 5'd9, 1'b1, 1'b1);
    push(32'h0, 32'h8, 3'd0, 5'd9, 1'b1, 1'b1);
    tick("lw_x9");
    drive(1'b1, 5'd2, 32'h20, 5'd9, 32'hBAD, 1'b1, 32'h1F, 3'd6, 5'd10, 1'b1, 1'b0);
    #1;
    chk("imm.id_ready", 32'(id_ready), 32'd1);
    push(32'h20, 32'h1F, 3'd6, 5'd10, 1'b1, 1'b0);
    tick("imm");

    // Downstream stall for three cycles, then release
    ex_ready = 1'b0;
    drive(1'b1, 5'd11, 32'h11, 5'd12, 32'h12, 1'b0, 32'd0, 3'd3, 5'd13, 1'b1, 1'b0);
    #1;
    chk("stall.id_ready", 32'(id_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick("stall");
      chk_hold("stall_hold");
      chk("stall.id_ready_hold", 32'(id_ready), 32'd0);
    end
    ex_ready = 1'b1;
    #1;
    chk("release.id_ready", 32'(id_ready), 32'd1);
    push(32'h11, 32'h12, 3'd3, 5'd13, 1'b1, 1'b0);
    tick("release");

    // Flush while FULL with a valid offer
    flush = 1'b1;
    drive(1'b1, 5'd2, 32'h2222, 5'd0, 32'd0, 1'b0, 32'd0, 3'd7, 5'd20, 1'b1, 1'b0);
    #1;
    chk("flush.id_ready", 32'(id_ready), 32'd0);
    tick("flush");
    chk("flush.valid", 32'(ex_valid), 32'd0);
    chk("flush.no_capture", operand_a, 32'h11);
    flush = 1'b0;

    // Reset in the middle of a downstream stall
    drive(1'b1, 5'd2, 32'hAAAA, 5'd0, 32'd0, 1'b0, 32'd0, 3'd2, 5'd14, 1'b1, 1'b0);
    push(32'hAAAA, 32'h0, 3'd2, 5'd14, 1'b1, 1'b0);
    tick("pre_rst");
    ex_ready = 1'b0;
    drive(1'b1, 5'd3, 32'hBBBB, 5'd0, 32'd0, 1'b0, 32'd0, 3'd1, 5'd15, 1'b1, 1'b0);
    tick("rst_stall");
    chk_hold("rst_stall_hold");
    rst = 1'b1;
    tick("mid_rst");
    chk_zero("mid_rst");
    rst = 1'b0;
    ex_ready = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 32'd0, 3'd0, 5'd0, 1'b0, 1'b0);

    // WB-only match: forwarded when compiled in, otherwise a one-cycle stall
    fwd_wb_rd = 5'd15; fwd_wb_we = 1'b1; fwd_wb_data = 32'hB0B;
    drive(1'b1, 5'd15, 32'hF00, 5'd0, 32'd0, 1'b0, 32'd0, 3'd4, 5'd16, 1'b1, 1'b0);
    #1;
`ifdef EX_FWD_WB_EN
    chk("wb.id_ready", 32'(id_ready), 32'd1);
    push(32'hB0B, 32'h0, 3'd4, 5'd16, 1'b1, 1'b0);
    tick("wb_fwd");
`else
    chk("wb.id_ready_stall", 32'(id_ready), 32'd0);
    tick("wb_stall");
    chk("wb.bubble_valid", 32'(ex_valid), 32'd0);
    clr_fwd();
    id_rs1_data = 32'hB0B;
    #1;
    chk("wb.id_ready_after", 32'(id_ready), 32'd1);
    push(32'hB0B, 32'h0, 3'd4, 5'd16, 1'b1, 1'b0);
    tick("wb_rf");
`endif
    id_valid = 1'b0;
    tick("drain");
    chk("drain.valid", 32'(ex_valid), 32'd0);
    chk("sb.empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
